idle_monitor: RTL and testbench
===============================

# idle_monitor

Per-peripheral activity monitor and wake conditioner that drives the `sleep_eligible` and `wake_evt` inputs of the peripheral power FSM.
- **Idle detection:** a saturating idle counter runs per peripheral. Once a peripheral has been continuously idle for a programmable number of cycles, its `sleep_eligible` bit is raised.
- **Wake conditioning:** raw, possibly asynchronous wake lines are synchronised and edge-detected. Each one becomes a single-cycle `wake_evt` pulse.

## Interface
- `N`, 4: number of peripherals.
- `CNT_W`, 16: idle counter and threshold width.
- `DEF_THRESH`, 1000: per-peripheral threshold loaded at reset. Must fit in `CNT_W`.
- `SYNC_STAGES`, 2: wake synchroniser depth, ≥2. Used only with `IDLE_MON_WAKE_SYNC_EN`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `activity` in `[N-1:0]`: synchronous busy level per peripheral.
- `wake_async` in `[N-1:0]`: raw wake level per peripheral.
- `cfg_we` in 1: threshold write strobe.
- `cfg_idx` in `[$clog2(N)-1:0]`: target peripheral for the write.
- `cfg_thresh` in `[CNT_W-1:0]`: threshold value to write.
- `sleep_eligible` out `[N-1:0]`: peripheral has been idle for at least its threshold.
- `wake_evt` out `[N-1:0]`: one-cycle wake pulse on a rising edge of the conditioned wake.

## Operation
**Per-peripheral registers:** `cnt[i]` (`CNT_W` bits) and `thr[i]` (`CNT_W` bits).

**Counter update** at each `clk` edge, in priority order:
1. `cfg_we && cfg_idx==i`: `thr[i]` ← `cfg_thresh` and `cnt[i]` ← 0.
2. `activity[i]` or `wake_evt[i]`: `cnt[i]` ← 0.
3. `cnt[i] < thr[i]`: `cnt[i]` ← `cnt[i]+1`.
4. Otherwise `cnt[i]` holds; it saturates at `thr[i]` and never wraps.

**Writes:**
- A write with `cfg_idx ≥ N` is ignored; no counter is cleared.
- Only one peripheral is written per cycle.

**sleep_eligible (combinational):** `sleep_eligible[i]` = (`cnt[i]==thr[i]`) && (`thr[i]!=0`) && `!activity[i]`.
- It drops in the same cycle that activity reasserts.
- `thr[i]==0` disables sleep eligibility for that peripheral permanently.

**Wake path:**
- Conditioned wake `w[i]` (see Configuration) is delayed one cycle into `w_q[i]`.
- `wake_evt[i]` = `w[i] && !w_q[i]`.
- A level held high yields exactly one pulse. Another pulse requires `w` to go low and then high again.

**Independence:** peripherals are fully independent; simultaneous events on different indices do not interact.

## Timing
**Reset values (asynchronous, immediate):**
- `cnt` = 0, `thr` = `DEF_THRESH`.
- All synchroniser flops and `w_q` = 0.
- `sleep_eligible` = 0 (because `cnt` = 0 and `DEF_THRESH` ≠ 0).
- `wake_evt` = 0.

**Idle latency:** with `activity[i]` low from edge 1 after reset release, `cnt[i]` = k after edge k. `sleep_eligible[i]` rises after edge `thr[i]` and stays high until activity, wake, or a write.

**Wake latency:**
- With sync: `wake_evt` rises `SYNC_STAGES` edges after the first edge that samples `wake_async` high, and lasts one cycle.
- Without sync: `wake_evt` rises combinationally in the same cycle as `wake_async`.

**Counter clear on wake:** the edge that ends a `wake_evt` cycle clears `cnt[i]`, so `sleep_eligible[i]` is low in the following cycle.

**Wake at reset release:** `wake_async` held high across reset release produces one `wake_evt` pulse after release.

**Reset mid-count:** the counter restarts from 0 and the threshold reverts to `DEF_THRESH`; previously written values are lost.

## Configuration
`IDLE_MON_WAKE_SYNC_EN`:
- **Defined:** `w[i]` is the output of a `SYNC_STAGES`-deep flop chain on `wake_async[i]`, all reset to 0, so the input may be fully asynchronous.
- **Undefined:** `w[i]` = `wake_async[i]` directly. The input must be synchronous to `clk`, and no synchroniser flops are built.

## Test plan
1. **Threshold write and idle count:** reset, write `thr[0]`=4, `activity`=0.
   - Required: `sleep_eligible[0]` rises exactly 4 edges after the write edge and stays high.
   - Required: the other bits stay 0 until 1000 edges have elapsed.
2. **Activity reassert:** with `sleep_eligible[2]`=1, pulse `activity[2]` for 1 cycle.
   - Required: `sleep_eligible[2]` drops in that cycle.
   - Required: with `thr`=8, it reasserts 8 edges after `activity` falls.
3. **Disable by zero threshold:** write `thr[1]`=0 and hold `activity`=0 for 2000 cycles.
   - Required: `sleep_eligible[1]` stays 0 throughout.
   - Required: a subsequent write of 3 yields assertion after 3 edges.
4. **Wake pulse with sync:** with `IDLE_MON_WAKE_SYNC_EN` defined, `SYNC_STAGES`=2, raise `wake_async[3]` and hold it for 10 cycles.
   - Required: exactly one `wake_evt[3]` pulse, 2 edges after first sampling.
   - Required: `cnt[3]` is cleared and `sleep_eligible[3]` is 0 the next cycle.
   - Without the macro: the pulse appears in the same cycle as the input.
5. **Reset mid-operation:** set `thr[0]`=5, let the counter reach 3, then assert `rst_n`=0 asynchronously mid-cycle.
   - Required: all outputs are 0 immediately.
   - Required: after release, `sleep_eligible[0]` rises only after 1000 idle edges.
6. **Ignored write and simultaneous events:** issue `cfg_we` with `cfg_idx`=N (N=5 build with a 3-bit index).
   - Required: no `thr` or `cnt` changes.
   - Required: a write to index 0 coinciding with `activity[0]`=1 loads `thr[0]` and clears `cnt[0]`.

Source files
------------

// File: rtl/idle_monitor.sv
// idle_monitor: per-peripheral idle counter and wake conditioner feeding the
// peripheral power FSM. Each peripheral raises sleep_eligible_o once it has
// been continuously idle for its programmable threshold, and each raw wake
// line becomes a single-cycle wake_evt_o pulse on its rising edge.
//
// Optional feature macro: IDLE_MON_WAKE_SYNC_EN
//   defined   - wake_async_i passes through a SYNC_STAGES-deep synchroniser
//   undefined - wake_async_i is used directly and must be synchronous to clk
module idle_monitor #(
    parameter int unsigned N           = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEF_THRESH  = 1000,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned IdxW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     activity_i,
    input  logic [N-1:0]     wake_async_i,
    input  logic             cfg_we_i,
    input  logic [IdxW-1:0]  cfg_idx_i,
    input  logic [CNT_W-1:0] cfg_thresh_i,
    output logic [N-1:0]     sleep_eligible_o,
    output logic [N-1:0]     wake_evt_o
);

    logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0][CNT_W-1:0] thr_q, thr_d;
    logic [N-1:0]            wake_cond;
    logic [N-1:0]            wake_cond_q;
    logic [N-1:0]            wake_evt;

`ifdef IDLE_MON_WAKE_SYNC_EN
    logic [SYNC_STAGES-1:0] sync_q [N];

    // Synchroniser chain per wake line; bit 0 samples the raw input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], wake_async_i[i]};
            end
        end
    end

    // Conditioned wake is the last synchroniser stage.
    always_comb begin
        wake_cond = '0;
        for (int unsigned i = 0; i < N; i++) begin
            wake_cond[i] = sync_q[i][SYNC_STAGES-1];
        end
    end
`else
    // Synchroniser depth only matters when the synchroniser is built.
    logic [31:0] unused_sync_stages;
    assign unused_sync_stages = SYNC_STAGES;

    assign wake_cond = wake_async_i;
`endif

    // One-cycle delayed copy of the conditioned wake for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wake_cond_q <= '0;
        end else begin
            wake_cond_q <= wake_cond;
        end
    end

    assign wake_evt   = wake_cond & ~wake_cond_q;
    assign wake_evt_o = wake_evt;

    // Threshold write has priority, then activity/wake clear, then saturating count.
    always_comb begin
        cnt_d = cnt_q;
        thr_d = thr_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (cfg_we_i && (cfg_idx_i == IdxW'(i))) begin
                thr_d[i] = cfg_thresh_i;
                cnt_d[i] = '0;
            end else if (activity_i[i] || wake_evt[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] < thr_q[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Counter and threshold registers; thresholds revert to the default on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
                thr_q[i] <= CNT_W'(DEF_THRESH);
            end
        end else begin
            cnt_q <= cnt_d;
            thr_q <= thr_d;
        end
    end

    // A zero threshold never qualifies; live activity drops eligibility at once.
    always_comb begin
        sleep_eligible_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sleep_eligible_o[i] = (cnt_q[i] == thr_q[i]) && (thr_q[i] != '0) &&
                                  !activity_i[i];
        end
    end

endmodule

// File: tb/tb_idle_monitor.sv
// Self-checking bench for idle_monitor: directed scenarios plus randomized
// traffic, compared every cycle against a behavioural model that tracks the
// number of idle edges since the last clear and the history of wake samples.
module tb_idle_monitor;

    localparam int unsigned N           = 5;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned DEF_THRESH  = 1000;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned IdxW        = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     activity;
    logic [N-1:0]     wake_async;
    logic             cfg_we;
    logic [IdxW-1:0]  cfg_idx;
    logic [CNT_W-1:0] cfg_thresh;
    logic [N-1:0]     sleep_eligible;
    logic [N-1:0]     wake_evt;

    idle_monitor #(
        .N           (N),
        .CNT_W       (CNT_W),
        .DEF_THRESH  (DEF_THRESH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .activity_i       (activity),
        .wake_async_i     (wake_async),
        .cfg_we_i         (cfg_we),
        .cfg_idx_i        (cfg_idx),
        .cfg_thresh_i     (cfg_thresh),
        .sleep_eligible_o (sleep_eligible),
        .wake_evt_o       (wake_evt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state.
    int m_thr  [N];
    int m_idle [N];                // idle edges since last clear (capped)
    bit m_hist [N][0:SYNC_STAGES]; // m_hist[i][0] = most recent wake sample

    function automatic bit m_w(int i);
`ifdef IDLE_MON_WAKE_SYNC_EN
        return m_hist[i][SYNC_STAGES-1];
`else
        return wake_async[i];
`endif
    endfunction

    function automatic bit m_wq(int i);
`ifdef IDLE_MON_WAKE_SYNC_EN
        return m_hist[i][SYNC_STAGES];
`else
        return m_hist[i][0];
`endif
    endfunction

    function automatic bit m_evt(int i);
        return m_w(i) && !m_wq(i);
    endfunction

    function automatic bit m_elig(int i);
        return (m_thr[i] != 0) && (m_idle[i] >= m_thr[i]) && !activity[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_thr[i]  = DEF_THRESH;
            m_idle[i] = 0;
            for (int s = 0; s <= SYNC_STAGES; s++) m_hist[i][s] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            bit ev;
            ev = m_evt(i);
            if (cfg_we && (int'(cfg_idx) == i)) begin
                m_thr[i]  = int'(cfg_thresh);
                m_idle[i] = 0;
            end else if (activity[i] || ev) begin
                m_idle[i] = 0;
            end else if (m_idle[i] < (1 << 20)) begin
                m_idle[i]++;
            end
            for (int s = SYNC_STAGES; s >= 1; s--) m_hist[i][s] = m_hist[i][s-1];
            m_hist[i][0] = wake_async[i];
        end
    endtask

    // Check outputs at the falling edge, then advance model at the rising edge.
    task automatic cycle();
        logic [N-1:0] exp_se, exp_we;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            exp_se[i] = m_elig(i);
            exp_we[i] = m_evt(i);
        end
        check_eq("sleep_eligible", 32'(sleep_eligible), 32'(exp_se));
        check_eq("wake_evt", 32'(wake_evt), 32'(exp_we));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic write_thr(input int idx, input int val);
        cfg_we     = 1'b1;
        cfg_idx    = IdxW'(idx);
        cfg_thresh = CNT_W'(val);
        cycle();
        cfg_we     = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] se_before;
        int           pulses;

        rst_n      = 1'b0;
        activity   = '0;
        wake_async = '0;
        cfg_we     = 1'b0;
        cfg_idx    = '0;
        cfg_thresh = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_sleep", 32'(sleep_eligible), 32'h0);
        check_eq("reset_wake", 32'(wake_evt), 32'h0);
        rst_n = 1'b1;

        // 1: threshold 4 on peripheral 0; others wait for the default 1000.
        write_thr(0, 4);
        for (int k = 1; k <= 4; k++) begin
            cycle();
            if (k == 3) check_eq("t1_se0_edge3", 32'(sleep_eligible[0]), 32'h0);
        end
        check_eq("t1_se0_edge4", 32'(sleep_eligible[0]), 32'h1);
        repeat (994) cycle();
        check_eq("t1_others_999", 32'(sleep_eligible[N-1:1]), 32'h0);
        cycle();
        check_eq("t1_others_1000", 32'(sleep_eligible[N-1:1]), 32'hF);

        // 2: activity pulse on an eligible peripheral with threshold 8.
        write_thr(2, 8);
        repeat (8) cycle();
        check_eq("t2_se2_up", 32'(sleep_eligible[2]), 32'h1);
        activity[2] = 1'b1;
        #1;
        check_eq("t2_se2_drop", 32'(sleep_eligible[2]), 32'h0);
        cycle();
        activity[2] = 1'b0;
        repeat (7) cycle();
        check_eq("t2_se2_edge7", 32'(sleep_eligible[2]), 32'h0);
        cycle();
        check_eq("t2_se2_edge8", 32'(sleep_eligible[2]), 32'h1);

        // 3: zero threshold disables eligibility; then threshold 3.
        write_thr(1, 0);
        repeat (2000) cycle();
        check_eq("t3_se1_disabled", 32'(sleep_eligible[1]), 32'h0);
        write_thr(1, 3);
        repeat (2) cycle();
        check_eq("t3_se1_edge2", 32'(sleep_eligible[1]), 32'h0);
        cycle();
        check_eq("t3_se1_edge3", 32'(sleep_eligible[1]), 32'h1);

        // 4: wake level held for 10 cycles gives exactly one pulse.
        pulses = 0;
        wake_async[3] = 1'b1;
        #1;
        if (wake_evt[3]) pulses++;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (wake_evt[3]) pulses++;
        end
        check_eq("t4_pulse_count", 32'(pulses), 32'h1);
        check_eq("t4_se3_cleared", 32'(sleep_eligible[3]), 32'h0);
        wake_async[3] = 1'b0;
        repeat (3) cycle();

        // 5: asynchronous reset in the middle of a count.
        write_thr(0, 5);
        repeat (3) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_sleep", 32'(sleep_eligible), 32'h0);
        check_eq("t5_rst_wake", 32'(wake_evt), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (999) cycle();
        check_eq("t5_se0_999", 32'(sleep_eligible[0]), 32'h0);
        cycle();
        check_eq("t5_se0_1000", 32'(sleep_eligible[0]), 32'h1);

        // 6: out-of-range write is ignored; write coinciding with activity.
        se_before = sleep_eligible;
        write_thr(5, 7);
        check_eq("t6_ignored_write", 32'(sleep_eligible), 32'(se_before));
        activity[0] = 1'b1;
        write_thr(0, 2);
        activity[0] = 1'b0;
        cycle();
        check_eq("t6_se0_edge1", 32'(sleep_eligible[0]), 32'h0);
        cycle();
        check_eq("t6_se0_edge2", 32'(sleep_eligible[0]), 32'h1);

        // Randomized traffic on all peripherals.
        for (int k = 0; k < 4000; k++) begin
            bit quiet;
            quiet = ((k / 200) % 2) == 1;
            for (int i = 0; i < N; i++) begin
                activity[i] = quiet ? 1'b0 : ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 19) == 0) wake_async[i] = ~wake_async[i];
            end
            cfg_we = ($urandom_range(0, 63) == 0);
            cfg_idx    = IdxW'($urandom_range(0, 7));
            cfg_thresh = CNT_W'($urandom_range(0, 20));
            cycle();
        end
        cfg_we = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
